dfp_burst_adapter: RTL and testbench

// - Memory-side responder for the cache dfp line interface; this is the block the cache dfp_read/dfp_write requests land on.
// - Converts one 256-bit line request into a 4-beat x 64-bit burst on the banked-memory (bmem) port.
// - Gathers read beats into dfp_rdata and splits dfp_wdata into write beats.
// - Sits between the dcache/icache stage-2 miss logic and the bmem model/arbiter.

---
 rtl/dfp_burst_adapter_if.sv | 38 +++
 rtl/dfp_burst_adapter.sv | 111 +++++++++++
 tb/tb_dfp_burst_adapter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dfp_burst_adapter_if.sv
// rtl/dfp_burst_adapter_if.sv - dfp line port and bmem burst port bundle for dfp_burst_adapter
interface dfp_burst_adapter_if #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int LINE_W = 256
);
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic              dfp_write;
    logic [LINE_W-1:0] dfp_wdata;
    logic              dfp_resp;
    logic [LINE_W-1:0] dfp_rdata;

    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    // Adapter side: answers dfp line requests, issues bmem bursts.
    modport slave (
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output dfp_resp, dfp_rdata,
        output bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    // System side: cache miss logic plus the bmem model/arbiter.
    modport master (
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  dfp_resp, dfp_rdata,
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/dfp_burst_adapter.sv
// rtl/dfp_burst_adapter.sv - 256-bit dfp line request to 4x64-bit bmem burst adapter (option: DFP_EARLY_WRITE_RESP_EN)
module dfp_burst_adapter #(
    parameter int BEAT_W    = 64,
    parameter int BURST_LEN = 4,
    parameter int LINE_W    = 256
) (
    input logic               clk,
    input logic               rst,
    dfp_burst_adapter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_CMD  = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_BEAT = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;
    localparam logic [2:0] S_TURN    = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       line_addr;
    // Shared line buffer: holds write data for a writeback, collects beats for a read.
    logic [LINE_W-1:0] buf_q;
    // Published read line; only replaced when a read completes.
    logic [LINE_W-1:0] rdata_q;
    logic              beat_hit;

`ifdef DFP_EARLY_WRITE_RESP_EN
    logic              early_resp_q;
`endif

    // Stale beats from an abandoned burst carry the old line address and are dropped.
    assign beat_hit = bus.bmem_rvalid && (bus.bmem_raddr == line_addr);

    // Transaction sequencer: latch request, run burst, respond, turn around.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            line_addr <= '0;
            buf_q     <= '0;
            rdata_q   <= '0;
`ifdef DFP_EARLY_WRITE_RESP_EN
            early_resp_q <= 1'b0;
`endif
        end else begin
`ifdef DFP_EARLY_WRITE_RESP_EN
            early_resp_q <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.dfp_write || bus.dfp_read) begin
                        line_addr <= bus.dfp_addr & LINE_MASK;
                        buf_q     <= bus.dfp_wdata;
                        cnt       <= '0;
                        state     <= bus.dfp_write ? S_WR_BEAT : S_RD_CMD;
`ifdef DFP_EARLY_WRITE_RESP_EN
                        early_resp_q <= bus.dfp_write;
`endif
                    end
                end
                S_RD_CMD: begin
                    if (bus.bmem_ready) begin
                        cnt   <= '0;
                        state <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (beat_hit) begin
                        buf_q[cnt*BEAT_W +: BEAT_W] <= bus.bmem_rdata;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            rdata_q <= {bus.bmem_rdata, buf_q[LINE_W-BEAT_W-1:0]};
                            state   <= S_RESP;
                        end
                    end
                end
                S_WR_BEAT: begin
                    if (bus.bmem_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
`ifdef DFP_EARLY_WRITE_RESP_EN
                            state <= S_IDLE;
`else
                            state <= S_RESP;
`endif
                        end
                    end
                end
                S_RESP:  state <= S_TURN;
                S_TURN:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Port outputs are decoded from state so they are all zero out of reset.
    assign bus.bmem_addr  = line_addr;
    assign bus.bmem_read  = (state == S_RD_CMD);
    assign bus.bmem_write = (state == S_WR_BEAT);
    assign bus.bmem_wdata = (state == S_WR_BEAT) ? buf_q[cnt*BEAT_W +: BEAT_W] : '0;
    assign bus.dfp_rdata  = rdata_q;
`ifdef DFP_EARLY_WRITE_RESP_EN
    assign bus.dfp_resp   = (state == S_RESP) || early_resp_q;
`else
    assign bus.dfp_resp   = (state == S_RESP);
`endif
endmodule

// File: tb/tb_dfp_burst_adapter.sv
// tb/tb_dfp_burst_adapter.sv - directed table-driven bench for dfp_burst_adapter
module tb_dfp_burst_adapter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dfp_burst_adapter_if bus();
    dfp_burst_adapter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] data;
        logic [4:0]   pat;
        logic [31:0]  exp_addr;
        logic [255:0] exp_rdata;
    } vec_t;

    vec_t         vecs[5];
    int           checks = 0;
    int           errors = 0;
    logic [255:0] last_rdata;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_resp"},       256'(bus.dfp_resp),   256'd0);
        check({tag, "_rdata"},      bus.dfp_rdata,        256'd0);
        check({tag, "_bmem_addr"},  256'(bus.bmem_addr),  256'd0);
        check({tag, "_bmem_read"},  256'(bus.bmem_read),  256'd0);
        check({tag, "_bmem_write"}, 256'(bus.bmem_write), 256'd0);
        check({tag, "_bmem_wdata"}, 256'(bus.bmem_wdata), 256'd0);
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [255:0] beats,
                            input logic [31:0] exp_addr, input logic [255:0] exp_rdata,
                            input int n_stale, input logic [31:0] stale_addr,
                            input logic [127:0] stale_beats, input bit hold);
        int n;
        bus.dfp_addr   = addr;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.bmem_read && n < 20);
        check("rd_cmd_latency", 256'(n), 256'd1);
        check("rd_bmem_addr", 256'(bus.bmem_addr), 256'(exp_addr));
        tick();
        check("rd_cmd_one_cycle", 256'(bus.bmem_read), 256'd0);
        for (int i = 0; i < n_stale; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = stale_addr;
            bus.bmem_rdata  = stale_beats[i*64 +: 64];
            tick();
            check("stale_no_resp", 256'(bus.dfp_resp), 256'd0);
        end
        for (int i = 0; i < 4; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = exp_addr;
            bus.bmem_rdata  = beats[i*64 +: 64];
            tick();
            if (i < 3) check("rd_no_early_resp", 256'(bus.dfp_resp), 256'd0);
        end
        bus.bmem_rvalid = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        check("rd_resp", 256'(bus.dfp_resp), 256'd1);
        check("rd_rdata", bus.dfp_rdata, exp_rdata);
        last_rdata = exp_rdata;
        if (!hold) bus.dfp_read = 1'b0;
        tick();
        check("rd_resp_one_cycle", 256'(bus.dfp_resp), 256'd0);
        check("turn_ignores_req", 256'(bus.bmem_read), 256'd0);
        tick();
        check("turn_ignores_req2", 256'(bus.bmem_read), 256'd0);
        check("rd_rdata_stable", bus.dfp_rdata, exp_rdata);
    endtask

    task automatic write_txn(input logic [31:0] addr, input logic [255:0] data,
                             input logic [4:0] pat, input logic [31:0] exp_addr, input bit with_read);
        int acc;
        int cyc;
        int resp_cnt;
        logic rdy;
        bus.dfp_addr   = addr;
        bus.dfp_wdata  = data;
        bus.dfp_write  = 1'b1;
        bus.dfp_read   = with_read;
        bus.bmem_ready = 1'b0;
        tick();
        bus.dfp_wdata = ~data;
        acc = 0;
        cyc = 0;
        resp_cnt = 0;
        while (acc < 4 && cyc < 20) begin
            rdy = (cyc < 5) ? pat[cyc] : 1'b1;
            bus.bmem_ready = rdy;
            check("wr_valid", 256'(bus.bmem_write), 256'd1);
            check("wr_no_read", 256'(bus.bmem_read), 256'd0);
            check("wr_addr", 256'(bus.bmem_addr), 256'(exp_addr));
            check("wr_beat", 256'(bus.bmem_wdata), 256'(data[acc*64 +: 64]));
            if (bus.dfp_resp) begin
                resp_cnt++;
                bus.dfp_write = 1'b0;
                bus.dfp_read  = 1'b0;
            end
            tick();
            if (rdy) acc++;
            cyc++;
        end
        bus.bmem_ready = 1'b0;
        check("wr_beats_done", 256'(acc), 256'd4);
`ifndef DFP_EARLY_WRITE_RESP_EN
        check("wr_resp_after_last", 256'(bus.dfp_resp), 256'd1);
`endif
        if (bus.dfp_resp) resp_cnt++;
        bus.dfp_write = 1'b0;
        bus.dfp_read  = 1'b0;
        check("wr_done", 256'(bus.bmem_write), 256'd0);
        check("wr_rdata_kept", bus.dfp_rdata, last_rdata);
        tick();
        if (bus.dfp_resp) resp_cnt++;
        tick();
        if (bus.dfp_resp) resp_cnt++;
        check("wr_resp_count", 256'(resp_cnt), 256'd1);
        check("wr_idle_no_read", 256'(bus.bmem_read), 256'd0);
    endtask

    initial begin
        vecs[0] = '{is_wr: 1'b0, addr: 32'h0000_1234,
                    data: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    pat: 5'b11111, exp_addr: 32'h0000_1220,
                    exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{is_wr: 1'b1, addr: 32'h0000_2008,
                    data: {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
                           64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000},
                    pat: 5'b11101, exp_addr: 32'h0000_2000, exp_rdata: '0};
        vecs[2] = '{is_wr: 1'b1, addr: 32'hFFFF_FFFF,
                    data: {64'hAAAA_5555_AAAA_5555, 64'h0123_4567_89AB_CDEF,
                           64'hFEDC_BA98_7654_3210, 64'h8000_0000_0000_0001},
                    pat: 5'b11111, exp_addr: 32'hFFFF_FFE0, exp_rdata: '0};
        vecs[3] = '{is_wr: 1'b0, addr: 32'hABCD_EF1F,
                    data: {64'hCAFE_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                           64'hF00D_0000_0000_0002, 64'hDEAD_0000_0000_0001},
                    pat: 5'b11111, exp_addr: 32'hABCD_EF00,
                    exp_rdata: {64'hCAFE_0000_0000_0004, 64'hBEEF_0000_0000_0003,
                                64'hF00D_0000_0000_0002, 64'hDEAD_0000_0000_0001}};
        vecs[4] = '{is_wr: 1'b1, addr: 32'h0000_0040,
                    data: {64'h0000_0000_0000_0044, 64'h0000_0000_0000_0033,
                           64'h0000_0000_0000_0022, 64'h0000_0000_0000_0011},
                    pat: 5'b01010, exp_addr: 32'h0000_0040, exp_rdata: '0};

        rst = 1'b1;
        bus.dfp_addr    = '0;
        bus.dfp_read    = 1'b0;
        bus.dfp_write   = 1'b0;
        bus.dfp_wdata   = '0;
        bus.bmem_ready  = 1'b0;
        bus.bmem_raddr  = '0;
        bus.bmem_rdata  = '0;
        bus.bmem_rvalid = 1'b0;
        last_rdata      = '0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].is_wr)
                write_txn(vecs[v].addr, vecs[v].data, vecs[v].pat, vecs[v].exp_addr, 1'b0);
            else
                read_txn(vecs[v].addr, vecs[v].data, vecs[v].exp_addr, vecs[v].exp_rdata,
                         0, 32'h0, 128'h0, 1'b0);
        end

        // Read and write together: the write must win.
        write_txn(32'h0000_3010, {64'h3, 64'h2, 64'h1, 64'h0}, 5'b11111, 32'h0000_3000, 1'b1);

        // Back-to-back reads with the request held through TURN.
        read_txn(32'h0000_0100, {64'hA4, 64'hA3, 64'hA2, 64'hA1}, 32'h0000_0100,
                 {64'hA4, 64'hA3, 64'hA2, 64'hA1}, 0, 32'h0, 128'h0, 1'b1);
        read_txn(32'h0000_0120, {64'hB4, 64'hB3, 64'hB2, 64'hB1}, 32'h0000_0120,
                 {64'hB4, 64'hB3, 64'hB2, 64'hB1}, 0, 32'h0, 128'h0, 1'b0);

        // Stray read beats while IDLE change nothing.
        bus.bmem_rvalid = 1'b1;
        bus.bmem_raddr  = 32'h0000_0120;
        bus.bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_no_resp", 256'(bus.dfp_resp), 256'd0);
            check("stray_rdata", bus.dfp_rdata, last_rdata);
        end
        bus.bmem_rvalid = 1'b0;
        tick();

        // Reset after beat 1 of a read, then a new read sees stale old beats first.
        bus.dfp_addr   = 32'h0000_1234;
        bus.dfp_read   = 1'b1;
        bus.bmem_ready = 1'b1;
        tick();
        check("abort_rd_cmd", 256'(bus.bmem_read), 256'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr  = 32'h0000_1220;
            bus.bmem_rdata  = 64'h0100 + 64'(i);
            tick();
            check("abort_no_resp", 256'(bus.dfp_resp), 256'd0);
        end
        bus.bmem_rvalid = 1'b0;
        bus.dfp_read    = 1'b0;
        rst = 1'b1;
        tick();
        check_zero_outputs("midrst");
        last_rdata = '0;
        rst = 1'b0;
        tick();
        check("midrst_no_resp", 256'(bus.dfp_resp), 256'd0);
        read_txn(32'h0000_0040, {64'hC4, 64'hC3, 64'hC2, 64'hC1}, 32'h0000_0040,
                 {64'hC4, 64'hC3, 64'hC2, 64'hC1}, 2, 32'h0000_1220,
                 {64'h0103, 64'h0102}, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
